// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// operation codes, FSM state encoding and operand-sign helpers.
package mul_div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MULH   = 4'b1001;
  localparam logic [3:0] OP_MULHSU = 4'b1010;
  localparam logic [3:0] OP_MULHU  = 4'b1011;
  localparam logic [3:0] OP_DIV    = 4'b1100;
  localparam logic [3:0] OP_DIVU   = 4'b1101;
  localparam logic [3:0] OP_REM    = 4'b1110;
  localparam logic [3:0] OP_REMU   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic op_signed_a(input logic [3:0] op);
    case (op)
      OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic op_signed_b(input logic [3:0] op);
    case (op)
      OP_MULH, OP_DIV, OP_REM: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] val, input logic neg);
    if (neg) begin
      return {XLEN{1'b0}} - val;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the shared datapath: add-shift multiply step or
// restoring trial-subtract divide step, chosen by is_div_i.
module mul_div_step
  import mul_div_unit_pkg::*;
(
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN:0]     rem_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN:0]     rem_o
);

  logic [XLEN:0]   sum_s;
  logic [XLEN+1:0] shifted_s;
  logic [XLEN:0]   diff_s;
  logic            fits_s;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide: acc low half shifts dividend bits out and quotient bits in.
  always_comb begin
    sum_s     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    shifted_s = {rem_i, acc_i[XLEN-1]};
    fits_s    = (shifted_s >= {2'b00, opnd_i});
    diff_s    = shifted_s[XLEN:0] - {1'b0, opnd_i};
    if (is_div_i) begin
      if (fits_s) begin
        rem_o = diff_s;
        acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b1};
      end else begin
        rem_o = shifted_s[XLEN:0];
        acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      rem_o = rem_i;
      acc_o = {sum_s, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32 RUN cycles per operation,
// with a single-cycle path for divide-by-zero and signed overflow.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [3:0]      ALU_Operation_i,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o,
  output logic            done_o
);
  import mul_div_unit_pkg::*;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sgn_a_s, sgn_b_s, div_zero_s, ovf_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, quot_s, rmdr_s;
  logic [2*XLEN-1:0] step_acc_s, prod_s;
  logic [XLEN:0]     step_rem_s;

  mul_div_step u_step (
    .is_div_i (op_q[2]),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .opnd_i   (opnd_q),
    .acc_o    (step_acc_s),
    .rem_o    (step_rem_s)
  );

  // Next-state, datapath and output-register logic for the IDLE/RUN/DONE sequence.
  always_comb begin
    sgn_a_s    = op_signed_a(ALU_Operation_i) & A_i[XLEN-1];
    sgn_b_s    = op_signed_b(ALU_Operation_i) & B_i[XLEN-1];
    a_mag_s    = magnitude(A_i, sgn_a_s);
    b_mag_s    = magnitude(B_i, sgn_b_s);
    div_zero_s = (B_i == {XLEN{1'b0}});
    ovf_s      = ((ALU_Operation_i == OP_DIV) || (ALU_Operation_i == OP_REM)) &&
                 (A_i == {1'b1, {(XLEN-1){1'b0}}}) && (B_i == {XLEN{1'b1}});
    prod_s     = neg_q ? ({(2*XLEN){1'b0}} - step_acc_s) : step_acc_s;
    quot_s     = neg_q ? ({XLEN{1'b0}} - step_acc_s[XLEN-1:0]) : step_acc_s[XLEN-1:0];
    rmdr_s     = rneg_q ? ({XLEN{1'b0}} - step_rem_s[XLEN-1:0]) : step_rem_s[XLEN-1:0];

    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i && ALU_Operation_i[3]) begin
          op_d   = ALU_Operation_i;
          cnt_d  = 5'd0;
          rem_d  = {(XLEN+1){1'b0}};
          neg_d  = sgn_a_s ^ sgn_b_s;
          rneg_d = sgn_a_s;
          if (ALU_Operation_i[2]) begin
            acc_d  = {{XLEN{1'b0}}, a_mag_s};
            opnd_d = b_mag_s;
          end else begin
            acc_d  = {{XLEN{1'b0}}, b_mag_s};
            opnd_d = a_mag_s;
          end
          // Special divide cases resolve without iterating; bit 1 selects remainder.
          if (ALU_Operation_i[2] && (div_zero_s || ovf_s)) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (div_zero_s) begin
              result_d = ALU_Operation_i[1] ? A_i : {XLEN{1'b1}};
            end else begin
              result_d = ALU_Operation_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
            end
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        acc_d = step_acc_s;
        rem_d = step_rem_s;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          case (op_q)
            OP_MUL:                      result_d = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             result_d = quot_s;
            OP_REM, OP_REMU:             result_d = rmdr_s;
            default:                     result_d = result_q;
          endcase
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 4'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= {(2*XLEN){1'b0}};
      rem_q    <= {(XLEN+1){1'b0}};
      opnd_q   <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result_o = result_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
